divchk_sched: RTL and testbench

- Shared serial divisibility checker with scheduler: NREQ requesters each present a WIDTH-bit word.
- A round-robin arbiter grants one requester at a time. The word is fed MSB-first into an internal mod-MOD residue state machine, one bit per clock.
- Each result is returned with the requester ID over a valid/ready handshake.
- The block sits between parallel producers and the bit-serial divisibility-detection datapath, sequencing and sharing that datapath.

---
 rtl/divchk_sched.sv | 92 +++++++++
 tb/tb_divchk_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divchk_sched.sv
// divchk_sched: round-robin scheduler sharing one bit-serial mod-MOD residue checker
module divchk_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int MOD   = 4,
    localparam int RW = $clog2(MOD),
    localparam int IW = $clog2(NREQ),
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IW-1:0]         res_id,
    output logic                  res_divisible,
    output logic [RW-1:0]         res_remainder,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    localparam logic [RW:0] MODV = MOD[RW:0];
    state_t state;
    logic [IW-1:0] rr_ptr, grant, cand;
    logic found;
    logic [WIDTH-1:0] shreg;
    logic [RW-1:0] residue, red;
    logic [RW:0] dbl;
    logic [CW-1:0] cnt;

    // round-robin search from rr_ptr; the smallest offset with a valid request wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // residue doubling plus incoming bit stays below 2*MOD, so one subtract reduces it
    always_comb begin
        dbl = {residue, shreg[WIDTH-1]};
        red = (dbl >= MODV) ? RW'(dbl - MODV) : RW'(dbl);
    end

    assign req_ready = (rstn && state == IDLE && found) ? NREQ'(1) << grant : '0;
    assign res_valid = state == RESP;
    assign busy      = state != IDLE;

    // job sequencing: accept a word, shift WIDTH bits through the residue, hold result until taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            shreg         <= '0;
            residue       <= '0;
            cnt           <= '0;
            res_id        <= '0;
            res_remainder <= '0;
            res_divisible <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    shreg   <= req_data[grant*WIDTH +: WIDTH];
                    residue <= '0;
                    cnt     <= CW'(WIDTH);
                    res_id  <= grant;
                    rr_ptr  <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    residue <= red;
                    shreg   <= shreg << 1;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        res_remainder <= red;
                        res_divisible <= red == '0;
                        state         <= RESP;
                    end
                end
                RESP: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divchk_sched.sv
// tb_divchk_sched: directed and randomized checks of divchk_sched against a job-level model
module tb_divchk_sched;
    localparam int NREQ = 4, WIDTH = 8, MOD = 4;
    localparam int RW = $clog2(MOD), IW = $clog2(NREQ);

    logic clk = 1'b0, rstn = 1'b0;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic res_valid, res_ready = 1'b1, res_divisible, busy;
    logic [IW-1:0] res_id;
    logic [RW-1:0] res_remainder;

    logic [1:0] s_valid = '0, r3_rdy, r5_rdy;
    logic [15:0] s_data = '0;
    logic r3_valid, r3_div, r3_busy, r3_id, r5_valid, r5_div, r5_busy, r5_id;
    logic [1:0] r3_rem;
    logic [2:0] r5_rem;

    int checks = 0, errors = 0;
    logic [NREQ-1:0] hs = '0;

    always #5 clk = ~clk;

    divchk_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_divisible(res_divisible), .res_remainder(res_remainder),
        .busy(busy));

    divchk_sched #(.NREQ(2), .WIDTH(8), .MOD(3)) dut3 (
        .clk(clk), .rstn(rstn), .req_valid(s_valid), .req_data(s_data),
        .req_ready(r3_rdy), .res_valid(r3_valid), .res_ready(1'b1),
        .res_id(r3_id), .res_divisible(r3_div), .res_remainder(r3_rem), .busy(r3_busy));

    divchk_sched #(.NREQ(2), .WIDTH(8), .MOD(5)) dut5 (
        .clk(clk), .rstn(rstn), .req_valid(s_valid), .req_data(s_data),
        .req_ready(r5_rdy), .res_valid(r5_valid), .res_ready(1'b1),
        .res_id(r5_id), .res_divisible(r5_div), .res_remainder(r5_rem), .busy(r5_busy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: phase 0 idle, 1..WIDTH shifting, WIDTH+1 result offered
    int m_ph = 0, m_ptr = 0, m_id = 0, m_rem = 0, m_div = 0;
    logic [WIDTH-1:0] m_word = '0;
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        g = -1;
        if (!rstn) begin
            m_ph = 0; m_ptr = 0; m_id = 0; m_rem = 0; m_div = 0;
        end else if (m_ph == 0) begin
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("res_valid", res_valid, rstn && m_ph == WIDTH + 1);
        chk("busy", busy, rstn && m_ph != 0);
        chk("res_id", res_id, m_id);
        chk("res_remainder", res_remainder, m_rem);
        chk("res_divisible", res_divisible, m_div);
        hs = req_valid & req_ready;
        if (rstn) begin
            if (g >= 0) begin
                m_id = g; m_ptr = (g + 1) % NREQ; m_word = req_data[g*WIDTH +: WIDTH]; m_ph = 1;
            end else if (m_ph > 0 && m_ph <= WIDTH) begin
                m_ph++;
                if (m_ph == WIDTH + 1) begin
                    m_rem = int'(m_word) % MOD;
                    m_div = (m_rem == 0) ? 1 : 0;
                end
            end else if (m_ph == WIDTH + 1 && res_ready) m_ph = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    task automatic wait_res(input string name, output int n);
        n = 0;
        while (!res_valid && n < 64) begin
            step();
            n++;
        end
        if (!res_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    logic [7:0] mw[5] = '{8'hFF, 8'h64, 8'h00, 8'h37, 8'h0D};
    int m3[5] = '{0, 1, 0, 1, 1};
    int m5[5] = '{0, 0, 0, 0, 3};

    initial begin
        int n, cyc, last, lows, jobs;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        rstn = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            s_valid = 2'b01;
            s_data[7:0] = mw[i];
            step();
            s_valid = '0;
            n = 0;
            while (!r3_valid && n < 40) begin step(); n++; end
            chk("m3_valid", r3_valid, 1);
            chk("m3_rem", r3_rem, m3[i]);
            chk("m3_div", r3_div, m3[i] == 0);
            chk("m5_rem", r5_rem, m5[i]);
            chk("m5_div", r5_div, m5[i] == 0);
            step();
        end

        req_valid = 4'b0001;
        req_data[7:0] = 8'h0C;
        #1 chk("grant0_ready", req_ready, 4'b0001);
        step();
        wait_res("lat0C", n);
        chk("latency", n, WIDTH);
        chk("r0C_id", res_id, 0);
        chk("r0C_rem", res_remainder, 0);
        chk("r0C_div", res_divisible, 1);
        step();
        req_valid = 4'b0001;
        req_data[7:0] = 8'h0D;
        step();
        wait_res("r0D", n);
        chk("r0D_rem", res_remainder, 1);
        chk("r0D_div", res_divisible, 0);
        step();

        @(posedge clk);
        #1 rstn = 1'b0;
        step();
        rstn = 1'b1;
        req_valid = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 4; k++) begin
            wait_res("order", n);
            chk("order_id", res_id, k);
            chk("order_rem", res_remainder, k);
            step();
        end
        req_valid = 4'b1010;
        req_data = {8'h37, 8'h00, 8'h21, 8'h00};
        wait_res("pair1", n);
        chk("pair_first", res_id, 1);
        chk("pair_rem1", res_remainder, 1);
        step();
        wait_res("pair3", n);
        chk("pair_second", res_id, 3);
        chk("pair_rem3", res_remainder, 3);
        step();

        res_ready = 1'b0;
        req_valid = 4'b0101;
        req_data = {8'h00, 8'h05, 8'h00, 8'h0E};
        wait_res("bp", n);
        chk("bp_id", res_id, 0);
        repeat (5) begin
            step();
            chk("bp_valid", res_valid, 1);
            chk("bp_hold_id", res_id, 0);
            chk("bp_hold_rem", res_remainder, 2);
            chk("bp_no_grant", req_ready, 0);
        end
        res_ready = 1'b1;
        step();
        chk("bp_released", res_valid, 0);
        chk("bp_next_grant", req_ready, 4'b0100);
        wait_res("bp2", n);
        chk("bp2_id", res_id, 2);
        chk("bp2_rem", res_remainder, 1);
        step();

        req_valid = 4'b0001;
        req_data = {8'h00, 8'h0B, 8'h00, 8'h0F};
        step();
        repeat (3) step();
        rstn = 1'b0;
        req_valid = 4'b0100;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_id", res_id, 0);
        chk("mid_rst_rem", res_remainder, 0);
        chk("mid_rst_div", res_divisible, 0);
        step();
        rstn = 1'b1;
        #1 chk("post_rst_grant", req_ready, 4'b0100);
        wait_res("post_rst", n);
        chk("post_rst_id", res_id, 2);
        chk("post_rst_rem", res_remainder, 3);
        chk("post_rst_div", res_divisible, 0);
        step();

        req_valid = 4'b0010;
        req_data[WIDTH +: WIDTH] = 8'h5A;
        last = -1; lows = 0; cyc = 0; jobs = 0;
        while (jobs < 5 && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
            if (hs[1]) begin
                if (last >= 0) begin
                    chk("stream_period", cyc - last, WIDTH + 2);
                    chk("stream_idle", lows, 1);
                end
                last = cyc; lows = 0; jobs++;
                req_data[WIDTH +: WIDTH] = WIDTH'($urandom);
            end else if (!busy) lows++;
        end
        if (jobs < 5) chk("stream_timeout", jobs, 5);
        req_valid = '0;
        repeat (WIDTH + 3) step();

        repeat (1500) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] || !req_valid[i]) begin
                    req_valid[i] = $urandom_range(0, 3) != 0;
                    case ($urandom_range(0, 5))
                        0: req_data[i*WIDTH +: WIDTH] = '0;
                        1: req_data[i*WIDTH +: WIDTH] = '1;
                        default: req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    endcase
                end else if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end
            res_ready = $urandom_range(0, 3) != 0;
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (3 * (WIDTH + 2)) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
